// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the iterative RV32M multiply/divide unit.
// The EX stage is the master; the unit is the slave.
interface mul_div_unit_if #(parameter int DATA_W = 32);
    logic              start;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic              flush;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        output start, funct3, rs1_val, rs2_val, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, flush,
        output busy, done, result
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M unit: 32-step shift-add multiply and restoring divide on operand magnitudes.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module mul_div_unit (
    input  logic          clk,
    input  logic          rst_n,
    mul_div_unit_if.slave bus
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [2:0]          op;
    logic [5:0]          cnt;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opb;
    logic                neg_q;
    logic                neg_r;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   result_q;

    logic                is_div;
    logic                sgn1;
    logic                sgn2;
    logic                div_zero;
    logic                div_ovf;
    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic [DATA_W-1:0]   fast_res;
    logic [2*DATA_W-1:0] step_acc;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W+1:0]   div_diff;

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic is_neg);
        logic signed [DATA_W-1:0] n;
        n = -v;
        return is_neg ? DATA_W'(n) : DATA_W'(v);
    endfunction

    // Apply the deferred sign to the raw magnitude result and pick the requested half.
    function automatic logic [DATA_W-1:0] finalize(input logic [2:0] f,
                                                   input logic [2*DATA_W-1:0] a,
                                                   input logic nq,
                                                   input logic nr);
        logic signed [2*DATA_W-1:0] prod;
        logic signed [DATA_W-1:0]   quot;
        logic signed [DATA_W-1:0]   rem;
        prod = nq ? -$signed(a) : $signed(a);
        quot = nq ? -$signed(a[DATA_W-1:0]) : $signed(a[DATA_W-1:0]);
        rem  = nr ? -$signed(a[2*DATA_W-1:DATA_W]) : $signed(a[2*DATA_W-1:DATA_W]);
        if (!f[2])
            return (f[1:0] == 2'b00) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
        else if (!f[1])
            return quot;
        else
            return rem;
    endfunction

    // Request decode: operand signedness, magnitudes and the fast-path cases.
    always_comb begin
        is_div   = bus.funct3[2];
        sgn1     = bus.rs1_val[DATA_W-1] &
                   (is_div ? ~bus.funct3[0] : (bus.funct3 == 3'b001 || bus.funct3 == 3'b010));
        sgn2     = bus.rs2_val[DATA_W-1] &
                   (is_div ? ~bus.funct3[0] : (bus.funct3 == 3'b001));
        mag1     = magnitude(bus.rs1_val, sgn1);
        mag2     = magnitude(bus.rs2_val, sgn2);
        div_zero = is_div && (bus.rs2_val == '0);
        div_ovf  = is_div && !bus.funct3[0] &&
                   (bus.rs1_val == 32'h8000_0000) && (bus.rs2_val == 32'hFFFF_FFFF);
        if (div_zero)
            fast_res = bus.funct3[1] ? bus.rs1_val : 32'hFFFF_FFFF;
        else
            fast_res = bus.funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end

    // One iteration: multiply adds then shifts right, divide shifts left then trial-subtracts.
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? opb : {DATA_W{1'b0}})};
        div_diff = {1'b0, acc[2*DATA_W-1:DATA_W-1]} - {2'b00, opb};
        if (!op[2])
            step_acc = {mul_sum, acc[DATA_W-1:1]};
        else if (!div_diff[DATA_W+1])
            step_acc = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
        else
            step_acc = {acc[2*DATA_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= '0;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.flush && bus.start) begin
                        op     <= bus.funct3;
                        cnt    <= '0;
                        neg_q  <= sgn1 ^ sgn2;
                        neg_r  <= sgn1;
                        busy_q <= 1'b1;
                        if (div_zero || div_ovf) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= fast_res;
                        end else begin
                            state <= CALC;
                            acc   <= {{DATA_W{1'b0}}, (is_div ? mag1 : mag2)};
                            opb   <= is_div ? mag2 : mag1;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc <= step_acc;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= finalize(op, step_acc, neg_q, neg_r);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
